// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: NREQ one-entry holding buffers feed the single register-file write port.
// Default is round-robin grant; define WB_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module wb_port_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            iwa_req_valid,
    input  logic [NREQ*REG_W-1:0]      iwa_req_reg,
    input  logic [NREQ*DATA_W-1:0]     iwa_req_data,
    output logic [NREQ-1:0]            owa_req_ready,
    input  logic                       iwa_flush,
    output logic                       owa_write_the_register,
    output logic [REG_W-1:0]           owa_write_reg_num,
    output logic [DATA_W-1:0]          owa_write_data,
    output logic [$clog2(NREQ+1)-1:0]  owa_pending
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(NREQ+1);

    logic [NREQ-1:0]   full;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   xfer;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_any;
    logic [REG_W-1:0]  hold_reg  [NREQ];
    logic [DATA_W-1:0] hold_data [NREQ];
    logic [CNT_W-1:0]  pending_cnt;

`ifdef WB_ARB_FIXED_PRIO_EN
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (full[i]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end
`else
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W:0]   cand;

    // Scan from the pointer upward with wraparound; the first full buffer wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NREQ)) cand = cand - (IDX_W+1)'(NREQ);
            if (!grant_any && full[cand[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    always_comb begin
        ptr_next = ptr;
        if (grant_any) begin
            ptr_next = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          ptr <= '0;
        else if (!iwa_flush) ptr <= ptr_next;
    end
`endif

    // Handshake: a write transfers on a rising edge when iwa_req_valid[i] and owa_req_ready[i]
    // are both high. Ready depends only on buffer state, the grant and flush, never on valid.
    assign owa_req_ready = (~full | grant) & {NREQ{~iwa_flush}};
    assign xfer          = iwa_req_valid & owa_req_ready;

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < NREQ; i++) pending_cnt = pending_cnt + CNT_W'(full[i]);
    end
    assign owa_pending = pending_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full                   <= '0;
            owa_write_the_register <= 1'b0;
            owa_write_reg_num      <= '0;
            owa_write_data         <= '0;
            for (int i = 0; i < NREQ; i++) begin
                hold_reg[i]  <= '0;
                hold_data[i] <= '0;
            end
        end else if (iwa_flush) begin
            full                   <= '0;
            owa_write_the_register <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (xfer[i]) begin
                    hold_reg[i]  <= iwa_req_reg[i*REG_W +: REG_W];
                    hold_data[i] <= iwa_req_data[i*DATA_W +: DATA_W];
                    full[i]      <= 1'b1;
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
            // Register 0 entries are consumed without raising the strobe.
            if (grant_any) begin
                owa_write_the_register <= (hold_reg[grant_idx] != '0);
                owa_write_reg_num      <= hold_reg[grant_idx];
                owa_write_data         <= hold_data[grant_idx];
            end else begin
                owa_write_the_register <= 1'b0;
            end
        end
    end

endmodule
